// File: rtl/ray_dispatch_pkg.sv
// Shared definitions for the ray dispatcher: FSM encoding, ray field layout
// and the default field count of a ray record.
package ray_dispatch_pkg;

  localparam int NFIELD = 13;

  // Field positions inside a packed ray record, field 0 at the LSB end.
  localparam int F_ORIGX = 0;
  localparam int F_ORIGY = 1;
  localparam int F_ORIGZ = 2;
  localparam int F_DIRX  = 3;
  localparam int F_DIRY  = 4;
  localparam int F_DIRZ  = 5;
  localparam int F_HITT  = 6;
  localparam int F_IDIRX = 7;
  localparam int F_IDIRY = 8;
  localparam int F_IDIRZ = 9;
  localparam int F_OODX  = 10;
  localparam int F_OODY  = 11;
  localparam int F_OODZ  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bit offset of a field inside a packed record of data_w-bit words.
  function automatic int field_lsb(input int field, input int data_w);
    return field * data_w;
  endfunction

endpackage

// File: rtl/ray_skid_fifo.sv
// Two-entry FIFO that holds returned ray records (address + data) until the
// traversal stage accepts them. Head entry does not move while not popped.
module ray_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ray_dispatch.sv
// Reads rays 0..ray_count-1 from the ray field RAMs and streams them, in
// index order, to the traversal stage over a valid/ready interface.
module ray_dispatch
  import ray_dispatch_pkg::*;
#(
  parameter int RAY_AW = 10,
  parameter int DATA_W = 32,
  parameter int NFIELD = ray_dispatch_pkg::NFIELD
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [RAY_AW:0]          ray_count,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_rd_en,
  output logic [RAY_AW-1:0]        mem_rd_addr,
  input  logic [NFIELD*DATA_W-1:0] mem_rd_data,
  output logic                     ray_valid,
  input  logic                     ray_ready,
  output logic [RAY_AW-1:0]        ray_id,
  output logic [NFIELD*DATA_W-1:0] ray_data,
  output state_e                   dbg_state_o
);

  // Handshake: a ray transfers on a cycle where ray_valid && ray_ready; while
  // ray_valid is high and ray_ready low, ray_id/ray_data hold their value and
  // ray_valid stays high.

  localparam int RW = NFIELD * DATA_W;
  localparam logic [RAY_AW:0] CNT_ONE = (RAY_AW+1)'(1);

  state_e              state_q, state_d;
  logic [RAY_AW:0]     count_q, count_d;
  logic [RAY_AW:0]     rd_cnt_q, rd_cnt_d;
  logic [RAY_AW:0]     pop_cnt_q, pop_cnt_d;
  logic                inflight_q;
  logic [RAY_AW-1:0]   inflight_addr_q;
  logic [1:0]          fifo_cnt;
  logic [2:0]          occ;
  logic                fifo_valid;
  logic                pop;
  logic                rd_ok;
  logic [RAY_AW+RW-1:0] fifo_dout;

  assign pop = fifo_valid && ray_ready;

  // Slots already claimed: stored entries plus the read whose data lands next
  // cycle, less the one leaving now. Two slots total, so a read needs occ < 2.
  assign occ   = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_ok = (state_q == ST_FETCH) && (rd_cnt_q < count_q) && (occ < 3'd2);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      count_q         <= '0;
      rd_cnt_q        <= '0;
      pop_cnt_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      rd_cnt_q        <= rd_cnt_d;
      pop_cnt_q       <= pop_cnt_d;
      inflight_q      <= rd_ok;
      inflight_addr_q <= rd_cnt_q[RAY_AW-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rd_cnt_d  = rd_ok ? rd_cnt_q + CNT_ONE : rd_cnt_q;
    pop_cnt_d = pop ? pop_cnt_q + CNT_ONE : pop_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d   = ray_count;
          rd_cnt_d  = '0;
          pop_cnt_d = '0;
          state_d   = (ray_count == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: if (rd_cnt_d == count_q) state_d = ST_DRAIN;
      ST_DRAIN: if (pop_cnt_d == count_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    mem_rd_en = rd_ok;
  end

  assign mem_rd_addr = rd_cnt_q[RAY_AW-1:0];
  assign dbg_state_o = state_q;

  ray_skid_fifo #(
    .W(RAY_AW + RW)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (inflight_q),
    .data_i  ({inflight_addr_q, mem_rd_data}),
    .pop_i   (pop),
    .valid_o (fifo_valid),
    .data_o  (fifo_dout),
    .count_o (fifo_cnt)
  );

  assign ray_valid          = fifo_valid;
  assign {ray_id, ray_data} = fifo_dout;

endmodule

// File: tb/tb_ray_dispatch.sv
// Directed bench for ray_dispatch: cycle-exact basic run, stalls, zero count,
// start while busy, mid-run reset and a full 1024-ray run with random ready.
module tb_ray_dispatch;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NF = 13;
  localparam int RW = NF * DW;

  // Basic 4-ray run, cycles 1..8 after start acceptance: {rd_en,valid,done,busy}.
  localparam logic [3:0]    T1_FLAGS [8] = '{4'b1001, 4'b1001, 4'b1101, 4'b1101,
                                             4'b0101, 4'b0101, 4'b0011, 4'b0000};
  localparam logic [AW-1:0] T1_ADDR  [8] = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd0, 10'd0, 10'd0, 10'd0};
  localparam logic [AW-1:0] T1_ID    [8] = '{10'd0, 10'd0, 10'd0, 10'd1, 10'd2, 10'd3, 10'd0, 10'd0};

  logic          clock;
  logic          reset;
  logic          start;
  logic [AW:0]   ray_count;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [RW-1:0] mem_rd_data;
  logic          ray_valid;
  logic          ray_ready;
  logic [AW-1:0] ray_id;
  logic [RW-1:0] ray_data;
  ray_dispatch_pkg::state_e dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_id;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_id;
  logic [RW-1:0] prev_data;

  ray_dispatch #(
    .RAY_AW(AW),
    .DATA_W(DW),
    .NFIELD(NF)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .ray_count   (ray_count),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .ray_valid   (ray_valid),
    .ray_ready   (ray_ready),
    .ray_id      (ray_id),
    .ray_data    (ray_data),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // Content of ray id: every field word is distinct and carries the id.
  function automatic logic [RW-1:0] ray_word(input logic [AW-1:0] id);
    logic [RW-1:0] r;
    r = '0;
    for (int f = 0; f < NF; f++) begin
      r[f*DW +: DW] = {4'(f), 4'hC, id[7:0] ^ 8'h5A, 6'b000000, id};
    end
    return r;
  endfunction

  // Synchronous ray RAM: data valid the cycle after the read strobe.
  always @(posedge clock) begin
    if (mem_rd_en) mem_rd_data <= ray_word(mem_rd_addr);
    else           mem_rd_data <= '1;
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every handshake must deliver the next expected id with its data.
  always @(negedge clock) begin
    if (reset && ray_valid && ray_ready) begin
      check("ray_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        exp_id = exp_q.pop_front();
        check("ray_id", ray_id, exp_id);
        check("ray_data", ray_data, ray_word(exp_id));
      end
    end
    if (reset && prev_stall) begin
      check("stall_valid", ray_valid, 1'b1);
      check("stall_id", ray_id, prev_id);
      check("stall_data", ray_data, prev_data);
    end
    prev_stall = reset && ray_valid && !ray_ready;
    prev_id    = ray_id;
    prev_data  = ray_data;
  end

  // Driver: one dispatch of cnt rays. ready low in cycles s_lo..s_hi (or random),
  // optional start re-pulse with count 9 in cycle rp.
  task automatic run(input string name, input int cnt, input int s_lo, input int s_hi,
                     input bit rnd, input int rp, input int budget, output int done_c);
    int n_rd;
    int outst;
    int max_outst;
    bit seen;
    n_rd = 0; outst = 0; max_outst = 0; seen = 0; done_c = 0;
    for (int i = 0; i < cnt; i++) exp_q.push_back(AW'(i));
    @(posedge clock); #1;
    start = 1'b1;
    ray_count = (AW+1)'(cnt);
    @(posedge clock); #1;
    start = 1'b0;
    for (int c = 1; c <= budget && !seen; c++) begin
      ray_ready = rnd ? 1'($urandom_range(0, 1)) : !(c >= s_lo && c <= s_hi);
      if (c == rp) begin
        start = 1'b1;
        ray_count = (AW+1)'(9);
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      if (mem_rd_en) n_rd++;
      outst = outst + int'(mem_rd_en) - int'(ray_valid && ray_ready);
      if (outst > max_outst) max_outst = outst;
      if (done) begin
        seen = 1;
        done_c = c;
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    ray_ready = 1'b1;
    check({name, "_done_seen"}, seen, 1'b1);
    check({name, "_reads"}, n_rd, cnt);
    check({name, "_outstanding_le2"}, max_outst <= 2, 1'b1);
    check({name, "_all_delivered"}, exp_q.size(), 0);
    @(negedge clock);
    check({name, "_busy_low"}, busy, 1'b0);
    exp_q.delete();
  endtask

  initial begin
    int  done_c;
    bit  seen_v;
    bit  seen_rd;
    reset = 1'b0;
    start = 1'b0;
    ray_count = '0;
    ray_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_flags", {busy, done, mem_rd_en, ray_valid}, 4'b0000);
    check("rst_addr", mem_rd_addr, 0);
    check("rst_id", ray_id, 0);
    check("rst_data", ray_data, 0);
    check("rst_state", dbg_state, ray_dispatch_pkg::ST_IDLE);
    @(posedge clock); #1;
    reset = 1'b1;

    // Cycle-exact 4-ray run with ready held high.
    for (int i = 0; i < 4; i++) exp_q.push_back(AW'(i));
    ray_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b1;
    ray_count = (AW+1)'(4);
    @(posedge clock); #1;
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      check($sformatf("basic_flags_c%0d", c), {mem_rd_en, ray_valid, done, busy}, T1_FLAGS[c-1]);
      if (T1_FLAGS[c-1][3]) check($sformatf("basic_addr_c%0d", c), mem_rd_addr, T1_ADDR[c-1]);
      if (T1_FLAGS[c-1][2]) check($sformatf("basic_id_c%0d", c), ray_id, T1_ID[c-1]);
      @(posedge clock); #1;
    end
    check("basic_all_delivered", exp_q.size(), 0);
    exp_q.delete();

    // Stall window, zero count, start while busy.
    run("stall", 5, 3, 8, 1'b0, 0, 100, done_c);
    run("zero", 0, 0, 0, 1'b0, 0, 20, done_c);
    check("zero_done_within_2", (done_c >= 1) && (done_c <= 2), 1'b1);
    run("repulse", 3, 0, 0, 1'b0, 2, 100, done_c);

    // Reset with two rays held in the FIFO.
    ray_ready = 1'b0;
    @(posedge clock); #1;
    start = 1'b1;
    ray_count = (AW+1)'(8);
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock);
    check("rstmid_pre_valid", ray_valid, 1'b1);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    check("rstmid_flags", {busy, done, mem_rd_en, ray_valid}, 4'b0000);
    check("rstmid_addr", mem_rd_addr, 0);
    check("rstmid_id", ray_id, 0);
    check("rstmid_data", ray_data, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    ray_ready = 1'b1;
    seen_v = 0;
    seen_rd = 0;
    repeat (10) begin
      @(negedge clock);
      seen_v  = seen_v | ray_valid;
      seen_rd = seen_rd | mem_rd_en | busy;
    end
    check("rstmid_no_valid", seen_v, 1'b0);
    check("rstmid_stays_idle", seen_rd, 1'b0);
    @(posedge clock); #1;

    // Full-size run with random back-pressure.
    run("full1024", 1024, 0, 0, 1'b1, 0, 6000, done_c);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ray_dispatch.md
RAY_DISPATCH -- requirements
Module: ray_dispatch

Interface
REQ-001 Parameter RAY_AW, default 10, is the ray-memory address width (max 1024 rays).
REQ-002 Parameter DATA_W, default 32, is the width of each ray field word.
REQ-003 Parameter NFIELD, default 13, is the number of fields per ray, packed field 0 at LSB: origx, origy, origz, dirx, diry, dirz, hitT, idirx, idiry, idirz, oodx, oody, oodz.
REQ-004 The block has one clock; reset is synchronous and active-low.
REQ-005 Port clock, input, 1: sole clock, rising edge.
REQ-006 Port reset, input, 1: synchronous reset, active-low; 0 sampled at a rising edge resets the block.
REQ-007 Port start, input, 1: one-cycle request to dispatch rays 0..ray_count-1.
REQ-008 Port ray_count, input, RAY_AW+1: number of rays, sampled only when start is accepted.
REQ-009 Port busy, output, 1: high from start acceptance until the done pulse, inclusive.
REQ-010 Port done, output, 1: one-cycle pulse after the last ray handshakes.
REQ-011 Port mem_rd_en, output, 1: read strobe to all ray field RAMs.
REQ-012 Port mem_rd_addr, output, RAY_AW: ray index being read.
REQ-013 Port mem_rd_data, input, NFIELD*DATA_W: concatenated RAM read data, valid exactly 1 cycle after mem_rd_en.
REQ-014 Port ray_valid, output, 1: ray record offered to the traversal stage.
REQ-015 Port ray_ready, input, 1: traversal stage accepts the record.
REQ-016 Port ray_id, output, RAY_AW: index of the offered ray.
REQ-017 Port ray_data, output, NFIELD*DATA_W: offered ray record.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, DRAIN, DONE.
REQ-019 IDLE: start=1 SHALL latch ray_count, clear read/issue counters, go to FETCH; ray_count=0 goes directly to DONE.
REQ-020 FETCH: mem_rd_en SHALL assert when (fifo_count + inflight - pop) < 2, addresses increment from 0; FETCH goes to DRAIN once ray_count reads are issued.
REQ-021 Return data SHALL be written with its address into a 2-entry output FIFO one cycle after the read; the FIFO SHALL never overflow.
REQ-022 ray_valid SHALL equal FIFO non-empty; the FIFO pops on ray_valid && ray_ready.
REQ-023 ray_id and ray_data SHALL stay stable while ray_valid=1 and ray_ready=0.
REQ-024 With ray_ready held high, sustained throughput SHALL be 1 ray/cycle; first ray_valid SHALL appear 2 cycles after start acceptance.
REQ-025 DRAIN SHALL go to DONE when ray_count rays have handshaked; DONE SHALL assert done for one cycle and return to IDLE.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 Rays SHALL be delivered strictly in index order, each exactly once.

Reset
REQ-028 On reset=0: state IDLE; busy, done, mem_rd_en, ray_valid = 0; mem_rd_addr, ray_id, ray_data = 0; FIFO empty; counters 0.
REQ-029 Reset mid-operation SHALL abort the dispatch, discard any in-flight read data and remain in IDLE until a new start.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the field-index constants and NFIELD.
REQ-031 The 2-entry FIFO SHALL be a sub-module named ray_skid_fifo.

Verification
REQ-032 ray_count=4, ray_ready=1: reads at addresses 0..3 on consecutive cycles, ray_id 0..3 on consecutive cycles starting 2 cycles after start, done 1 cycle after ray 3.
REQ-033 ray_count=5, ray_ready low for cycles 3-8: at most 2 reads outstanding, ray_data stable while stalled, all 5 rays delivered in order.
REQ-034 ray_count=0: no mem_rd_en, done pulses within 2 cycles, busy returns to 0.
REQ-035 start re-pulsed while busy with ray_count=9: ignored, original count of 3 rays delivered.
REQ-036 reset=0 asserted with 2 rays in flight: all outputs 0 the next cycle, no ray_valid until a new start.
REQ-037 ray_count=1024 with random ray_ready: each mem_rd_data word matches its ray_id at the output, no loss or duplication.
